// File: rtl/axi_dram_responder_if.sv
// AXI4 bus bundle between a DRAM performance master and its responder.
// ID width 6, address 64, data 512 bits.
interface axi4_bus_t;
   logic [5:0]   awid;
   logic [63:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid;
   logic         awready;
   logic [511:0] wdata;
   logic [63:0]  wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic [5:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [5:0]   arid;
   logic [63:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready;
   logic [5:0]   rid;
   logic [511:0] rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;

   // Responder view of the bus.
   modport master (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_dram_responder.sv
// AXI4 responder backed by a line-addressed 512-bit memory. Independent
// read and write FSMs, one burst outstanding each, size forced to 64 bytes,
// INCR bursts wrapping modulo the memory depth. Read data returns after a
// programmable latency; memory is read-first on same-line collisions.
module axi_dram_responder #(
   parameter int MEM_AW     = 10,
   parameter int RD_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   axi4_bus_t.master   axi,
   output logic        wlast_err,
   output logic [31:0] rd_beats,
   output logic [31:0] wr_beats
);
   localparam int         DEPTH      = 1 << MEM_AW;
   localparam logic [7:0] LAT_RELOAD = 8'(RD_LATENCY - 1);

   typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_WAIT = 2'd1, RD_DATA = 2'd2} rd_state_t;

   logic [511:0] mem_r [DEPTH];

   wr_state_t          wr_state_r, wr_next_s;
   logic [MEM_AW-1:0]  wr_line_r, wr_mem_line_s;
   logic [7:0]         wr_len_r, wr_cnt_r;
   logic [5:0]         bid_r;
   logic               awready_r, wready_r, bvalid_r, wlast_err_r;
   logic [31:0]        wr_beats_r;
   logic               aw_hs_s, w_hs_s, b_hs_s, w_final_s;

   rd_state_t          rd_state_r, rd_next_s;
   logic [MEM_AW-1:0]  rd_line_r, rd_load_line_s, ar_line_s;
   logic [7:0]         rd_len_r, rd_len_nxt_s, rd_beat_r, rd_beat_nxt_s, lat_cnt_r;
   logic [5:0]         rid_r;
   logic [511:0]       rdata_r;
   logic               arready_r, rvalid_r, rlast_r, rd_load_s;
   logic [31:0]        rd_beats_r;
   logic               ar_hs_s, r_hs_s;

   assign aw_hs_s       = axi.awvalid && awready_r;
   assign w_hs_s        = axi.wvalid && wready_r;
   assign b_hs_s        = bvalid_r && axi.bready;
   assign w_final_s     = (wr_cnt_r == wr_len_r);
   assign wr_mem_line_s = wr_line_r + MEM_AW'(wr_cnt_r);
   assign ar_hs_s       = axi.arvalid && arready_r;
   assign r_hs_s        = rvalid_r && axi.rready;
   assign ar_line_s     = axi.araddr[6+MEM_AW-1:6];

   // Write FSM next state: burst length is decided by awlen alone.
   always_comb begin
      wr_next_s = wr_state_r;
      case (wr_state_r)
         WR_IDLE: begin
            if (aw_hs_s) wr_next_s = WR_DATA;
            else         wr_next_s = WR_IDLE;
         end
         WR_DATA: begin
            if (w_hs_s && w_final_s) wr_next_s = WR_RESP;
            else                     wr_next_s = WR_DATA;
         end
         WR_RESP: begin
            if (b_hs_s) wr_next_s = WR_IDLE;
            else        wr_next_s = WR_RESP;
         end
         default: wr_next_s = WR_IDLE;
      endcase
   end

   // Write-side state, burst context, registered handshake outputs and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_r  <= WR_IDLE;
         awready_r   <= 1'b1;
         wready_r    <= 1'b0;
         bvalid_r    <= 1'b0;
         bid_r       <= 6'd0;
         wr_line_r   <= '0;
         wr_len_r    <= 8'd0;
         wr_cnt_r    <= 8'd0;
         wlast_err_r <= 1'b0;
         wr_beats_r  <= 32'd0;
      end else begin
         wr_state_r <= wr_next_s;
         awready_r  <= (wr_next_s == WR_IDLE);
         wready_r   <= (wr_next_s == WR_DATA);
         bvalid_r   <= (wr_next_s == WR_RESP);
         if (aw_hs_s) begin
            bid_r     <= axi.awid;
            wr_line_r <= axi.awaddr[6+MEM_AW-1:6];
            wr_len_r  <= axi.awlen;
            wr_cnt_r  <= 8'd0;
         end else if (w_hs_s) begin
            wr_cnt_r <= wr_cnt_r + 8'd1;
         end
         if (w_hs_s && (axi.wlast != w_final_s)) wlast_err_r <= 1'b1;
         if (w_hs_s) wr_beats_r <= wr_beats_r + 32'd1;
      end
   end

   // Byte-strobed memory write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_hs_s) begin
         for (int i = 0; i < 64; i++) begin
            if (axi.wstrb[i]) mem_r[wr_mem_line_s][i*8 +: 8] <= axi.wdata[i*8 +: 8];
         end
      end
   end

   // Read FSM next state plus rdata-register load line selection.
   always_comb begin
      rd_next_s      = rd_state_r;
      rd_load_s      = 1'b0;
      rd_load_line_s = rd_line_r;
      rd_beat_nxt_s  = rd_beat_r;
      rd_len_nxt_s   = rd_len_r;
      case (rd_state_r)
         RD_IDLE: begin
            if (ar_hs_s) begin
               rd_len_nxt_s  = axi.arlen;
               rd_beat_nxt_s = 8'd0;
               if (RD_LATENCY == 1) begin
                  rd_next_s      = RD_DATA;
                  rd_load_s      = 1'b1;
                  rd_load_line_s = ar_line_s;
               end else begin
                  rd_next_s = RD_WAIT;
               end
            end else begin
               rd_next_s = RD_IDLE;
            end
         end
         RD_WAIT: begin
            if (lat_cnt_r <= 8'd1) begin
               rd_next_s = RD_DATA;
               rd_load_s = 1'b1;
            end else begin
               rd_next_s = RD_WAIT;
            end
         end
         RD_DATA: begin
            if (r_hs_s) begin
               if (rd_beat_r == rd_len_r) begin
                  rd_next_s = RD_IDLE;
               end else begin
                  rd_beat_nxt_s  = rd_beat_r + 8'd1;
                  rd_load_s      = 1'b1;
                  rd_load_line_s = rd_line_r + MEM_AW'(rd_beat_nxt_s);
               end
            end else begin
               rd_next_s = RD_DATA;
            end
         end
         default: rd_next_s = RD_IDLE;
      endcase
   end

   // Read-side state, latency countdown, rdata register and beat counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_r <= RD_IDLE;
         arready_r  <= 1'b1;
         rvalid_r   <= 1'b0;
         rlast_r    <= 1'b0;
         rid_r      <= 6'd0;
         rdata_r    <= 512'd0;
         rd_line_r  <= '0;
         rd_len_r   <= 8'd0;
         rd_beat_r  <= 8'd0;
         lat_cnt_r  <= 8'd0;
         rd_beats_r <= 32'd0;
      end else begin
         rd_state_r <= rd_next_s;
         arready_r  <= (rd_next_s == RD_IDLE);
         rvalid_r   <= (rd_next_s == RD_DATA);
         rlast_r    <= (rd_next_s == RD_DATA) && (rd_beat_nxt_s == rd_len_nxt_s);
         rd_beat_r  <= rd_beat_nxt_s;
         rd_len_r   <= rd_len_nxt_s;
         if (ar_hs_s) begin
            rid_r     <= axi.arid;
            rd_line_r <= ar_line_s;
            lat_cnt_r <= LAT_RELOAD;
         end else if (rd_state_r == RD_WAIT) begin
            lat_cnt_r <= lat_cnt_r - 8'd1;
         end
         if (rd_load_s) rdata_r <= mem_r[rd_load_line_s];
         if (r_hs_s) rd_beats_r <= rd_beats_r + 32'd1;
      end
   end

   assign axi.awready = awready_r;
   assign axi.wready  = wready_r;
   assign axi.bvalid  = bvalid_r;
   assign axi.bid     = bid_r;
   assign axi.bresp   = 2'b00;
   assign axi.arready = arready_r;
   assign axi.rvalid  = rvalid_r;
   assign axi.rid     = rid_r;
   assign axi.rdata   = rdata_r;
   assign axi.rresp   = 2'b00;
   assign axi.rlast   = rlast_r;
   assign wlast_err   = wlast_err_r;
   assign rd_beats    = rd_beats_r;
   assign wr_beats    = wr_beats_r;
endmodule

// File: tb/tb_axi_dram_responder.sv
// Scoreboard bench for axi_dram_responder (MEM_AW=4, RD_LATENCY=4).
module tb_axi_dram_responder;
   typedef struct packed {
      logic [511:0] data;
      logic         last;
      logic [5:0]   id;
   } rexp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wlast_err;
   logic [31:0] rd_beats, wr_beats;

   axi4_bus_t axi_bus();

   axi_dram_responder #(.MEM_AW(4), .RD_LATENCY(4)) dut (
      .clk(clk), .rst_n(rst_n), .axi(axi_bus),
      .wlast_err(wlast_err), .rd_beats(rd_beats), .wr_beats(wr_beats)
   );

   always #5 clk = ~clk;

   int n_vectors = 0;
   int n_miscompares = 0;
   int cyc = 0;
   rexp_t exp_r[$];
   logic [5:0] exp_b[$];
   logic [511:0] model [16];
   logic [511:0] wbuf [64];
   logic [63:0]  sbuf [64];
   logic         lbuf [64];
   int w_cyc_arr [64];
   int ar_cyc, rv_cyc, rlast_cyc, b_cyc, last_w_cyc, wle_cyc;
   int b_count = 0, r_pop = 0;
   logic r_first = 1'b0, rr_toggle = 1'b0;
   logic stall_prev = 1'b0, hold_last = 1'b0, wle_prev = 1'b0;
   logic [511:0] hold_data, last_rdata;

   task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] want);
      n_vectors++;
      if (got !== want) begin
         n_miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // cycle counter
   initial forever begin @(posedge clk); cyc++; end

   // rready driver: steady or alternating
   initial begin
      axi_bus.rready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rr_toggle) axi_bus.rready = !axi_bus.rready;
         else           axi_bus.rready = 1'b1;
      end
   end

   // output monitor: pops scoreboard on R/B handshakes, checks stall hold
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (stall_prev) begin
            check_value("r_hold_valid", 512'(axi_bus.rvalid), 512'(1));
            check_value("r_hold_data", axi_bus.rdata, hold_data);
            check_value("r_hold_last", 512'(axi_bus.rlast), 512'(hold_last));
         end
         stall_prev = axi_bus.rvalid && !axi_bus.rready;
         hold_data  = axi_bus.rdata;
         hold_last  = axi_bus.rlast;
         if (axi_bus.rvalid && axi_bus.rready) begin
            if (exp_r.size() == 0) begin
               check_value("r_unexpected", 512'(1), 512'(0));
            end else begin
               rexp_t e;
               e = exp_r.pop_front();
               check_value("rdata", axi_bus.rdata, e.data);
               check_value("rlast", 512'(axi_bus.rlast), 512'(e.last));
               check_value("rid", 512'(axi_bus.rid), 512'(e.id));
               check_value("rresp", 512'(axi_bus.rresp), 512'(0));
               last_rdata = axi_bus.rdata;
               if (r_first) begin rv_cyc = cyc; r_first = 1'b0; end
               if (axi_bus.rlast) rlast_cyc = cyc;
               r_pop++;
            end
         end
         if (axi_bus.bvalid && axi_bus.bready) begin
            if (exp_b.size() == 0) begin
               check_value("b_unexpected", 512'(1), 512'(0));
            end else begin
               check_value("bid", 512'(axi_bus.bid), 512'(exp_b.pop_front()));
               check_value("bresp", 512'(axi_bus.bresp), 512'(0));
            end
            b_cyc = cyc;
            b_count++;
         end
         if (wlast_err && !wle_prev) wle_cyc = cyc;
         wle_prev = wlast_err;
      end else begin
         stall_prev = 1'b0;
         wle_prev   = 1'b0;
      end
   end

   task automatic aw_send(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
      int k = 0;
      axi_bus.awid = id; axi_bus.awaddr = addr; axi_bus.awlen = len;
      axi_bus.awsize = 3'd0; axi_bus.awburst = 2'd0; axi_bus.awvalid = 1'b1;
      @(negedge clk);
      while (!axi_bus.awready && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) check_value("aw_timeout", 512'(0), 512'(1));
      exp_b.push_back(id);
      @(posedge clk); #1;
      axi_bus.awvalid = 1'b0;
      check_value("aw_busy", 512'(axi_bus.awready), 512'(0));
   endtask

   task automatic w_send(input int len, input logic [3:0] line);
      for (int n = 0; n <= len; n++) begin
         int k = 0;
         logic [3:0] ln;
         axi_bus.wdata = wbuf[n]; axi_bus.wstrb = sbuf[n];
         axi_bus.wlast = lbuf[n]; axi_bus.wvalid = 1'b1;
         @(negedge clk);
         while (!axi_bus.wready && k < 100) begin @(negedge clk); k++; end
         if (k >= 100) check_value("w_timeout", 512'(0), 512'(1));
         ln = line + 4'(n);
         for (int b = 0; b < 64; b++)
            if (sbuf[n][b]) model[ln][b*8 +: 8] = wbuf[n][b*8 +: 8];
         w_cyc_arr[n] = cyc;
         last_w_cyc   = cyc;
         @(posedge clk); #1;
      end
      axi_bus.wvalid = 1'b0;
      axi_bus.wlast  = 1'b0;
   endtask

   task automatic ar_send(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
      int k = 0;
      logic [3:0] line;
      axi_bus.arid = id; axi_bus.araddr = addr; axi_bus.arlen = len;
      axi_bus.arsize = 3'd0; axi_bus.arburst = 2'd0; axi_bus.arvalid = 1'b1;
      @(negedge clk);
      while (!axi_bus.arready && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) check_value("ar_timeout", 512'(0), 512'(1));
      line = addr[9:6];
      for (int n = 0; n <= int'(len); n++)
         exp_r.push_back('{data: model[line + 4'(n)], last: (n == int'(len)), id: id});
      ar_cyc  = cyc;
      r_first = 1'b1;
      @(posedge clk); #1;
      axi_bus.arvalid = 1'b0;
      check_value("ar_busy", 512'(axi_bus.arready), 512'(0));
   endtask

   task automatic wait_b(input int target);
      int k = 0;
      while (b_count < target && k < 200) begin @(posedge clk); #1; k++; end
      check_value("b_done", 512'(b_count), 512'(target));
   endtask

   task automatic wait_r();
      int k = 0;
      while (exp_r.size() != 0 && k < 500) begin @(posedge clk); #1; k++; end
      check_value("r_done", 512'(exp_r.size()), 512'(0));
   endtask

   task automatic set_wbuf(input int len, input int mode);
      for (int n = 0; n <= len; n++) begin
         case (mode)
            0:       wbuf[n] = {16{32'(n)}};
            default: wbuf[n] = {16{$urandom()}};
         endcase
         sbuf[n] = {64{1'b1}};
         lbuf[n] = (n == len);
      end
   endtask

   initial begin
      int b0, r0, p0;
      logic [511:0] old9, want5;
      axi_bus.awvalid = 1'b0; axi_bus.wvalid = 1'b0; axi_bus.arvalid = 1'b0;
      axi_bus.bready = 1'b1;  axi_bus.wlast = 1'b0;
      axi_bus.awid = 6'd0; axi_bus.awaddr = 64'd0; axi_bus.awlen = 8'd0;
      axi_bus.awsize = 3'd0; axi_bus.awburst = 2'd0;
      axi_bus.arid = 6'd0; axi_bus.araddr = 64'd0; axi_bus.arlen = 8'd0;
      axi_bus.arsize = 3'd0; axi_bus.arburst = 2'd0;
      axi_bus.wdata = 512'd0; axi_bus.wstrb = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      // reset values
      check_value("rst_ctrl", 512'({axi_bus.awready, axi_bus.arready, axi_bus.wready,
                  axi_bus.bvalid, axi_bus.rvalid, axi_bus.rlast}), 512'(6'b110000));
      check_value("rst_ids", 512'({axi_bus.bid, axi_bus.rid, axi_bus.bresp, axi_bus.rresp}), 512'(0));
      check_value("rst_rdata", axi_bus.rdata, 512'd0);
      check_value("rst_cnt", 512'({wlast_err, rd_beats, wr_beats}), 512'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // write then read, line 1, 4 beats
      set_wbuf(3, 0);
      aw_send(6'd3, 64'h40, 8'd3);
      w_send(3, 4'd1);
      wait_b(1);
      check_value("b_latency", 512'(b_cyc - last_w_cyc), 512'(1));
      ar_send(6'd5, 64'h40, 8'd3);
      wait_r();
      check_value("r_latency", 512'(rv_cyc - ar_cyc), 512'(4));
      check_value("r_stream", 512'(rlast_cyc - rv_cyc), 512'(3));
      check_value("rd_beats_4", 512'(rd_beats), 512'(4));
      check_value("wr_beats_4", 512'(wr_beats), 512'(4));

      // fill all 16 lines with random data
      set_wbuf(15, 1);
      aw_send(6'd1, 64'h0, 8'd15);
      w_send(15, 4'd0);
      wait_b(2);

      // partial strobe on line 5
      wbuf[0] = {512{1'b1}}; sbuf[0] = {64{1'b1}}; lbuf[0] = 1'b1;
      aw_send(6'd2, 64'h140, 8'd0);
      w_send(0, 4'd5);
      wait_b(3);
      wbuf[0] = 512'd0; sbuf[0] = 64'h00000000_0000000F;
      aw_send(6'd2, 64'h140, 8'd0);
      w_send(0, 4'd5);
      wait_b(4);
      ar_send(6'd6, 64'h140, 8'd0);
      wait_r();
      want5 = {{60{8'hFF}}, 32'h0000_0000};
      check_value("partial_strobe", last_rdata, want5);

      // 64-beat read with alternating rready
      r0 = int'(rd_beats);
      rr_toggle = 1'b1;
      ar_send(6'd7, 64'h80, 8'd63);
      wait_r();
      rr_toggle = 1'b0;
      @(posedge clk); #1;
      check_value("rd_beats_64", 512'(rd_beats - 32'(r0)), 512'(64));

      // wlast asserted early on beat 1 of a 3-beat burst
      set_wbuf(2, 1);
      lbuf[0] = 1'b0; lbuf[1] = 1'b1; lbuf[2] = 1'b0;
      b0 = b_count;
      p0 = int'(wr_beats);
      check_value("wlast_err_pre", 512'(wlast_err), 512'(0));
      aw_send(6'd9, 64'h200, 8'd2);
      w_send(2, 4'd8);
      wait_b(b0 + 1);
      repeat (3) @(posedge clk);
      #1;
      check_value("wlast_err", 512'(wlast_err), 512'(1));
      check_value("wlast_err_when", 512'(wle_cyc), 512'(w_cyc_arr[1] + 1));
      check_value("wlast_one_b", 512'(b_count - b0), 512'(1));
      check_value("wlast_beats", 512'(wr_beats - 32'(p0)), 512'(3));

      // wrap: 2 beats from line 15 land in lines 15 and 0
      set_wbuf(1, 1);
      b0 = b_count;
      aw_send(6'd4, 64'h3C0, 8'd1);
      w_send(1, 4'd15);
      wait_b(b0 + 1);
      ar_send(6'd8, 64'h0, 8'd0);
      wait_r();
      check_value("wrap_line0", last_rdata, wbuf[1]);

      // same-line collision: write beat lands on the rdata load cycle
      old9 = model[9];
      set_wbuf(0, 1);
      b0 = b_count;
      fork
         ar_send(6'd10, 64'h240, 8'd0);
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            aw_send(6'd11, 64'h240, 8'd0);
            w_send(0, 4'd9);
         end
      join
      wait_b(b0 + 1);
      wait_r();
      check_value("collide_timing", 512'(w_cyc_arr[0] - ar_cyc), 512'(3));
      check_value("collide_old", last_rdata, old9);
      ar_send(6'd12, 64'h240, 8'd0);
      wait_r();
      check_value("collide_new", last_rdata, wbuf[0]);

      // reset during beat 2 of an 8-beat read
      p0 = r_pop;
      ar_send(6'd13, 64'h0, 8'd7);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_value("rst_mid_rvalid", 512'(axi_bus.rvalid), 512'(0));
      check_value("rst_mid_arready", 512'(axi_bus.arready), 512'(1));
      check_value("rst_mid_cnt", 512'({rd_beats, wr_beats}), 512'(0));
      check_value("rst_mid_beats", 512'(r_pop - p0), 512'(2));
      exp_r.delete();
      r_first = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      ar_send(6'd14, 64'h0, 8'd3);
      wait_r();
      check_value("post_rst_latency", 512'(rv_cyc - ar_cyc), 512'(4));
      check_value("post_rst_rd_beats", 512'(rd_beats), 512'(4));

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule

// File: doc/axi_dram_responder.md
# axi_dram_responder

AXI4 responder (slave-side model) serving the DRAM performance masters in `cl_dram_perf`. It accepts 512-bit INCR bursts on independent read and write paths, backed by an internal line-addressed memory. It returns read data after a programmable latency and issues one write response per burst. It stands in for the DDR controller in simulation and in loopback builds, and counts beats for bandwidth cross-checking.

## Interface
- `MEM_AW`, default 10: memory depth is 2^MEM_AW lines of 64 bytes.
- `RD_LATENCY`, default 4, legal range 1..255: cycles from AR handshake to first `rvalid`.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `axi`  `axi4_bus_t.master`  —  responder side of the bus. The block drives awready, wready, bid/bresp/bvalid, arready and rid/rdata/rresp/rlast/rvalid. It samples all other fields.
- `wlast_err`  out  1  sticky flag: wlast did not coincide with the final counted beat.
- `rd_beats`  out  32  count of R beats accepted (rvalid && rready). Wraps.
- `wr_beats`  out  32  count of W beats accepted (wvalid && wready). Wraps.

## Operation
- Addressing:
  - Line index = addr[6+MEM_AW-1:6]. Byte offset and upper bits are ignored, so addresses wrap modulo depth.
  - arsize/awsize are treated as 3'b110 regardless of value. Burst type is treated as INCR.
  - Beat n of a burst targets line (index + n) mod 2^MEM_AW.
- Memory has no reset; contents persist across `rst_n`.
- Write FSM, states WR_IDLE → WR_DATA → WR_RESP:
  - WR_IDLE: awready=1. On awvalid, capture awid, line index and awlen; beat counter=0; go to WR_DATA.
  - WR_DATA: wready=1. Each accepted beat writes the bytes with wstrb[i]=1 and increments the counter. On the beat where counter==awlen, go to WR_RESP.
  - The end of the burst is decided by awlen only. If wlast differs from (counter==awlen) on any beat, set `wlast_err`. Only reset clears it.
  - WR_RESP: bvalid=1, bid=captured awid, bresp=2'b00. On bready, return to WR_IDLE.
- Read FSM, states RD_IDLE → RD_WAIT → RD_DATA:
  - RD_IDLE: arready=1. On arvalid, capture arid, index and arlen. Load the latency counter; go to RD_WAIT.
  - RD_WAIT: count down. Pre-load the rdata register from line `index` one cycle before entering RD_DATA.
  - RD_DATA: rvalid=1, rid=captured arid, rresp=2'b00, rlast=(beat==arlen).
    - On a handshake that is not the last beat, load the rdata register from the next line in the same cycle, so beats stream back-to-back.
    - On the rlast handshake, return to RD_IDLE.
- Read and write paths are fully independent; each has one burst outstanding.
- Same-line collision: if a write and an rdata-register load hit the same line in one cycle, the read returns the pre-write data (read-first).

## Timing
- Reset values:
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - bid=0, rid=0, bresp=0, rresp=0, rdata=0.
  - wlast_err=0, rd_beats=0, wr_beats=0.
  - Both FSMs in IDLE.
- Asserting reset mid-burst immediately abandons the burst. No B or R handshake is owed afterwards.
- AR handshake at cycle T → first rvalid at T+RD_LATENCY. Beats then arrive one per cycle while rready=1; a burst of L+1 beats ends at T+RD_LATENCY+L.
- rvalid, rdata, rid and rlast hold steady while rready=0.
- AW handshake at T → wready from T+1. Final W beat at cycle U → bvalid at U+1.
- bvalid, bid and bresp hold steady until bready.
- arready and awready are deasserted from the cycle after their handshake until the burst completes. The next AR/AW can be accepted no earlier than the cycle after the rlast or B handshake.
- Counters increment on the handshake cycle and update at the next edge.

## Test plan
- Write then read, with RD_LATENCY=4:
  - AW addr 0x40, awlen 3, wdata beat n = {16{n}}, wstrb all ones, then AR same address and length.
  - Required: bvalid 1 cycle after beat 3, bresp 0; rvalid exactly 4 cycles after the AR handshake; beats 0..3 back-to-back with rlast on beat 3.
  - Required afterwards: rd_beats=4, wr_beats=4.
- Partial strobe:
  - Write line 5 with all-ones data and wstrb all ones, then write line 5 with zero data and wstrb 64'h00000000_0000000F.
  - Required: a read of line 5 returns bytes 0..3 = 0x00 and bytes 4..63 = 0xFF.
- rready backpressure:
  - 64-beat read with rready toggling 1010…
  - Required: no beat lost or duplicated; rdata and rlast stable while stalled; rd_beats=64.
- wlast error:
  - awlen 2, wlast asserted on beat 1.
  - Required: wlast_err=1 after beat 1; burst still takes 3 beats; one B response.
- Wrap and collision:
  - MEM_AW=4, write line 15 with awlen 1.
  - Required: second beat lands in line 0.
  - Then a concurrent write and read of the same line.
  - Required: the read returns the old data.
- Reset mid-read:
  - Assert rst_n=0 during RD_DATA beat 2.
  - Required: rvalid=0 immediately; arready=1; counters=0.
  - Required: a subsequent read returns the memory contents written before reset.
